// File: rtl/gpa_fhdo_dac_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_dac_responder_pkg
//  Description : Shared framing constants, address map and FSM state type
//                for the GPA-FHDO DAC SPI link. Both the serialiser and the
//                responder import this package so the two ends agree on the
//                frame layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpa_fhdo_dac_responder_pkg;

    // Default frame length and bit positions inside a frame word
    localparam int FRAME_BITS_DEF = 24;
    localparam int RNW_BIT        = 23;

    // Register address map
    localparam logic [3:0] ADDR_NOP    = 4'h0;
    localparam logic [3:0] ADDR_ID     = 4'h1;
    localparam logic [3:0] ADDR_CONFIG = 4'h3;
    localparam logic [3:0] ADDR_DAC0   = 4'h8;
    localparam logic [3:0] ADDR_DAC1   = 4'h9;
    localparam logic [3:0] ADDR_DAC2   = 4'hA;
    localparam logic [3:0] ADDR_DAC3   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // DAC channels occupy 0x8..0xB, so the channel index is addr[1:0]
    function automatic logic is_dac_addr(input logic [3:0] addr);
        return (addr[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpa_fhdo_dac_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_dac_responder_if
//  Description : SPI link between the gradient serialiser (master) and the
//                DAC responder (slave).
//  Signals     : fhd_clk_i  SCLK, CPOL=0
//                fhd_sdo_i  MOSI
//                fhd_ssn_i  chip select, active low
//                fhd_sdi_o  MISO
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpa_fhdo_dac_responder_if;
    logic fhd_clk_i;
    logic fhd_sdo_i;
    logic fhd_ssn_i;
    logic fhd_sdi_o;

    modport master (
        output fhd_clk_i,
        output fhd_sdo_i,
        output fhd_ssn_i,
        input  fhd_sdi_o
    );

    modport slave (
        input  fhd_clk_i,
        input  fhd_sdo_i,
        input  fhd_ssn_i,
        output fhd_sdi_o
    );
endinterface
`default_nettype wire

// File: rtl/gpa_fhdo_dac_responder_spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_dac_responder_spi_sync_edge
//  Description : Multi-stage synchroniser for one asynchronous SPI input,
//                with single-cycle rise/fall pulses from the synced copy.
//  Ports       : clk, rst   system clock, synchronous active-high reset
//                din        asynchronous input pin
//                sync       synchronised level
//                rise/fall  1-cycle pulses on synced transitions
//  Revision    : 1.0 - initial release
// ============================================================================
module gpa_fhdo_dac_responder_spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      sync,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Whole chain resets to 0: a pin that is already low (e.g. SSN held
    // during a mid-frame reset) then produces no false falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain[0] <= 1'b0;
        end else begin
            chain[0] <= din;
        end
    end

    for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                chain[i] <= 1'b0;
            end else begin
                chain[i] <= chain[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/gpa_fhdo_dac_responder.sv
`default_nettype none
// ============================================================================
//  Module      : gpa_fhdo_dac_responder
//  Description : SPI responder for the GPA-FHDO 4-channel DAC link. Samples
//                the SPI pins on clk, deframes 24-bit words, applies writes
//                to DAC0..3/CONFIG and returns read data on MISO during the
//                following frame.
//  Ports       : clk, rst        system clock (>=4x SCLK), sync active-high rst
//                spi             SPI slave modport (SCLK/MOSI/SSN in, MISO out)
//                dac0_o..dac3_o  DAC channel codes
//                config_o        CONFIG register
//                wr_strobe_o     1-cycle pulse per accepted write frame
//                wr_addr_o       address of the last write frame
//                frame_err_o     1-cycle pulse per discarded frame
//                err_cnt_o       saturating count of discarded frames
//  Revision    : 1.0 - initial release
// ============================================================================
module gpa_fhdo_dac_responder
    import gpa_fhdo_dac_responder_pkg::*;
#(
    parameter int          FRAME_BITS  = FRAME_BITS_DEF,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] DEVICE_ID   = 16'h0504,
    parameter logic [15:0] RESET_CODE  = 16'h8000
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    gpa_fhdo_dac_responder_if.slave        spi,
    output logic [15:0]                    dac0_o,
    output logic [15:0]                    dac1_o,
    output logic [15:0]                    dac2_o,
    output logic [15:0]                    dac3_o,
    output logic [15:0]                    config_o,
    output logic                           wr_strobe_o,
    output logic [3:0]                     wr_addr_o,
    output logic                           frame_err_o,
    output logic [7:0]                     err_cnt_o
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX   = 5'd31;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic ssn_sync,  ssn_rise,  ssn_fall;

    gpa_fhdo_dac_responder_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.fhd_clk_i),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    gpa_fhdo_dac_responder_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.fhd_sdo_i),
        .sync (mosi_sync),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    gpa_fhdo_dac_responder_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ssn (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.fhd_ssn_i),
        .sync (ssn_sync),
        .rise (ssn_rise),
        .fall (ssn_fall)
    );

    // Only the edges of SCLK and the level of MOSI are needed
    logic unused_sync;
    assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t       state;
    logic         armed;
    logic [23:0]  shift_reg;
    logic [4:0]   bit_cnt;
    logic [23:0]  readback;
    logic [23:0]  tx_reg;
    logic         sdi_q;
    logic [15:0]  dac_q [4];
    logic [15:0]  config_q;

    logic [3:0]   cmd_addr;
    logic [15:0]  cmd_data;
    logic         cmd_read;
    logic [15:0]  rd_data;

    assign cmd_addr = shift_reg[19:16];
    assign cmd_data = shift_reg[15:0];
    assign cmd_read = shift_reg[RNW_BIT];

    // Register read mux; unmapped addresses (and NOP) read as 0
    always_comb begin
        rd_data = '0;
        if (is_dac_addr(cmd_addr)) begin
            rd_data = dac_q[cmd_addr[1:0]];
        end else if (cmd_addr == ADDR_ID) begin
            rd_data = DEVICE_ID;
        end else if (cmd_addr == ADDR_CONFIG) begin
            rd_data = config_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, register file and readback shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            readback    <= '0;
            tx_reg      <= '0;
            sdi_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dac_q[i] <= RESET_CODE;
            end
            config_q    <= '0;
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= '0;
            frame_err_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            wr_strobe_o <= 1'b0;
            frame_err_o <= 1'b0;

            // A frame already in progress at reset release must not be
            // picked up halfway; wait until SSN has been seen high.
            if (ssn_sync) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    sdi_q <= 1'b0;
                    if (ssn_fall && armed) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        sdi_q     <= readback[23];
                        tx_reg    <= {readback[22:0], 1'b0};
                    end
                end

                ST_SHIFT: begin
                    // SSN rise takes priority over a coincident SCLK edge
                    if (ssn_rise) begin
                        state <= ST_DONE;
                        sdi_q <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            shift_reg <= {shift_reg[22:0], mosi_sync};
                            if (bit_cnt != CNT_MAX) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            sdi_q  <= tx_reg[23];
                            tx_reg <= {tx_reg[22:0], 1'b0};
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    if (bit_cnt == FRAME_CNT) begin
                        if (cmd_read) begin
                            readback <= {shift_reg[23:16], rd_data};
                        end else begin
                            readback    <= '0;
                            wr_strobe_o <= 1'b1;
                            wr_addr_o   <= cmd_addr;
                            if (is_dac_addr(cmd_addr)) begin
                                dac_q[cmd_addr[1:0]] <= cmd_data;
                            end else if (cmd_addr == ADDR_CONFIG) begin
                                config_q <= cmd_data;
                            end
                        end
                    end else begin
                        frame_err_o <= 1'b1;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi.fhd_sdi_o = sdi_q;
    assign dac0_o        = dac_q[0];
    assign dac1_o        = dac_q[1];
    assign dac2_o        = dac_q[2];
    assign dac3_o        = dac_q[3];
    assign config_o      = config_q;

endmodule
`default_nettype wire

// File: tb/tb_gpa_fhdo_dac_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpa_fhdo_dac_responder
//  Description : Directed, table-driven bench for the GPA-FHDO DAC responder.
//                Each table row is one SPI frame with the full register
//                snapshot, strobe/error pulses and MISO word expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpa_fhdo_dac_responder;

    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dac0_o, dac1_o, dac2_o, dac3_o, config_o;
    logic        wr_strobe_o, frame_err_o;
    logic [3:0]  wr_addr_o;
    logic [7:0]  err_cnt_o;

    gpa_fhdo_dac_responder_if spi ();

    gpa_fhdo_dac_responder dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi.slave),
        .dac0_o      (dac0_o),
        .dac1_o      (dac1_o),
        .dac2_o      (dac2_o),
        .dac3_o      (dac3_o),
        .config_o    (config_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .frame_err_o (frame_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_seen = 0;
    int err_seen    = 0;

    always @(negedge clk) begin
        if (wr_strobe_o) strobe_seen++;
        if (frame_err_o) err_seen++;
    end

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          strobes;
        logic [3:0]  wr_addr;
        int          errs;
        logic [7:0]  err_cnt;
        logic [15:0] d0, d1, d2, d3, cfg;
        bit          chk_miso;
        logic [23:0] miso;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SSN-low frame, MSB first; MISO sampled on each SCLK rise.
    // rst_at >= 0 pulses rst just before that bit index is sent.
    task automatic spi_frame(input logic [31:0] word, input int nbits,
                             input int rst_at, output logic [31:0] miso);
        miso = '0;
        spi.fhd_ssn_i = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                wait_clks(2);
                rst = 1'b0;
            end
            spi.fhd_sdo_i = word[nbits-1-i];
            wait_clks(HALF);
            spi.fhd_clk_i = 1'b1;
            miso = {miso[30:0], spi.fhd_sdi_o};
            wait_clks(HALF);
            spi.fhd_clk_i = 1'b0;
        end
        spi.fhd_sdo_i = 1'b0;
        wait_clks(HALF);
        spi.fhd_ssn_i = 1'b1;
        wait_clks(2*HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] miso;
        int s0, e0;

        //            word        nb  str addr errs ecnt  d0       d1       d2       d3       cfg     chk miso
        vecs[0]  = '{32'h081234, 24, 1, 4'h8, 0, 8'd0, 16'h1234, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 24'h000000};
        vecs[1]  = '{32'h09AAAA, 24, 1, 4'h9, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h8000, 16'h8000, 16'h0000, 1'b1, 24'h000000};
        vecs[2]  = '{32'h0A5555, 24, 1, 4'hA, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'h8000, 16'h0000, 1'b1, 24'h000000};
        vecs[3]  = '{32'h0BFFFF, 24, 1, 4'hB, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 1'b1, 24'h000000};
        vecs[4]  = '{32'h0300C3, 24, 1, 4'h3, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[5]  = '{32'h810000, 24, 0, 4'h3, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[6]  = '{32'h000000, 24, 1, 4'h0, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h810504};
        vecs[7]  = '{32'h830000, 24, 0, 4'h0, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[8]  = '{32'h880000, 24, 0, 4'h0, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h8300C3};
        vecs[9]  = '{32'h8B0000, 24, 0, 4'h0, 0, 8'd0, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h881234};
        vecs[10] = '{32'h081111, 23, 0, 4'h0, 1, 8'd1, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b0, 24'h000000};
        vecs[11] = '{32'h0A1111, 25, 0, 4'h0, 1, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b0, 24'h000000};
        vecs[12] = '{32'h000000, 24, 1, 4'h0, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h8BFFFF};
        vecs[13] = '{32'h01FFFF, 24, 1, 4'h1, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[14] = '{32'h051111, 24, 1, 4'h5, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[15] = '{32'h810000, 24, 0, 4'h5, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[16] = '{32'h850000, 24, 0, 4'h5, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h810504};
        vecs[17] = '{32'h000000, 24, 1, 4'h0, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h850000};
        vecs[18] = '{32'hF10000, 24, 0, 4'h0, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};
        vecs[19] = '{32'h000000, 24, 1, 4'h0, 0, 8'd2, 16'h1234, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'hF10504};
        vecs[20] = '{32'h784321, 24, 1, 4'h8, 0, 8'd2, 16'h4321, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h00C3, 1'b1, 24'h000000};

        spi.fhd_clk_i = 1'b0;
        spi.fhd_sdo_i = 1'b0;
        spi.fhd_ssn_i = 1'b1;
        rst = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(8);

        // Reset state
        check("rst dac0",   32'(dac0_o),      32'h8000);
        check("rst dac1",   32'(dac1_o),      32'h8000);
        check("rst dac2",   32'(dac2_o),      32'h8000);
        check("rst dac3",   32'(dac3_o),      32'h8000);
        check("rst config", 32'(config_o),    32'h0000);
        check("rst miso",   32'(spi.fhd_sdi_o), 32'h0);
        check("rst errcnt", 32'(err_cnt_o),   32'h0);
        check("rst wraddr", 32'(wr_addr_o),   32'h0);
        check("rst strobe", 32'(wr_strobe_o), 32'h0);
        check("rst ferr",   32'(frame_err_o), 32'h0);

        // Table-driven frames
        for (int i = 0; i < 21; i++) begin
            s0 = strobe_seen;
            e0 = err_seen;
            spi_frame(vecs[i].word, vecs[i].nbits, -1, miso);
            check($sformatf("v%0d strobes", i), 32'(strobe_seen - s0), 32'(vecs[i].strobes));
            check($sformatf("v%0d ferrs",   i), 32'(err_seen - e0),    32'(vecs[i].errs));
            check($sformatf("v%0d wraddr",  i), 32'(wr_addr_o),        32'(vecs[i].wr_addr));
            check($sformatf("v%0d errcnt",  i), 32'(err_cnt_o),        32'(vecs[i].err_cnt));
            check($sformatf("v%0d dac0",    i), 32'(dac0_o),           32'(vecs[i].d0));
            check($sformatf("v%0d dac1",    i), 32'(dac1_o),           32'(vecs[i].d1));
            check($sformatf("v%0d dac2",    i), 32'(dac2_o),           32'(vecs[i].d2));
            check($sformatf("v%0d dac3",    i), 32'(dac3_o),           32'(vecs[i].d3));
            check($sformatf("v%0d config",  i), 32'(config_o),         32'(vecs[i].cfg));
            if (vecs[i].chk_miso) begin
                check($sformatf("v%0d miso", i), 32'(miso[23:0]), 32'(vecs[i].miso));
            end
        end

        // Load a non-zero readback, then reset in the middle of a write
        spi_frame(32'h880000, 24, -1, miso);
        check("pre-rst miso", 32'(miso[23:0]), 32'h000000);
        s0 = strobe_seen;
        e0 = err_seen;
        spi_frame(32'h091357, 24, 12, miso);
        check("midrst strobes", 32'(strobe_seen - s0), 32'd0);
        check("midrst ferrs",   32'(err_seen - e0),    32'd0);
        check("midrst dac0",    32'(dac0_o),   32'h8000);
        check("midrst dac1",    32'(dac1_o),   32'h8000);
        check("midrst dac3",    32'(dac3_o),   32'h8000);
        check("midrst config",  32'(config_o), 32'h0000);
        check("midrst errcnt",  32'(err_cnt_o), 32'h0);
        check("midrst wraddr",  32'(wr_addr_o), 32'h0);

        // SCLK toggling with SSN high must be ignored
        for (int k = 0; k < 5; k++) begin
            spi.fhd_sdo_i = k[0];
            spi.fhd_clk_i = 1'b1;
            wait_clks(HALF);
            spi.fhd_clk_i = 1'b0;
            wait_clks(HALF);
        end
        spi.fhd_sdo_i = 1'b0;
        check("idle sclk ferrs", 32'(err_seen - e0), 32'd0);

        // Next frame works normally; readback was cleared by the reset
        s0 = strobe_seen;
        spi_frame(32'h0A2468, 24, -1, miso);
        check("post-rst miso",    32'(miso[23:0]), 32'h000000);
        check("post-rst dac2",    32'(dac2_o),     32'h2468);
        check("post-rst dac0",    32'(dac0_o),     32'h8000);
        check("post-rst strobes", 32'(strobe_seen - s0), 32'd1);
        check("post-rst wraddr",  32'(wr_addr_o),  32'hA);
        check("post-rst errcnt",  32'(err_cnt_o),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
